system_memory_controller: RTL and testbench

- Sequencer for the system memory (grid state register with serial load, parallel run capture and serial readout).
- Accepts one host command at a time (LOAD, RUN, OUTPUT) and drives the memory's mutually exclusive LOAD_MODE / RUN_MODE / OUTPUT_MODE strobes for the exact number of cycles.
- Counts serial bits and generations, and reports completion.
- Sits between the host/IO shim and the system memory plus next-state grid logic.

---
 rtl/system_memory_controller.sv | 199 +++++++++++++++++++
 tb/tb_system_memory_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_memory_controller.sv
// -----------------------------------------------------------------------------
// system_memory_controller
//
// Sequences the system memory, which is a grid state register with a serial
// load path, a parallel "run" capture, and a serial readout path. The host
// issues one command at a time: LOAD, RUN or OUTPUT. For each command the
// controller drives exactly one of the memory strobes LOAD_MODE, RUN_MODE or
// OUTPUT_MODE for the required number of cycles. It counts the serial bits and
// the generations, and it pulses DONE on normal completion.
//
// Ports
//   CLK               system clock; all state changes on the rising edge
//   RESET             asynchronous reset, active low
//   CMD_VALID/READY   host command handshake (READY is high only in IDLE)
//   CMD_OP            00 NOP, 01 LOAD, 10 RUN, 11 OUTPUT
//   CMD_GENS          generation count for RUN, captured when accepted
//   ABORT             cancels the operation in progress (no DONE)
//   HOST_SERIAL_IN    serial load bit from the host
//   HOST_SERIAL_VALID marks HOST_SERIAL_IN as valid
//   MEM_SERIAL_OUT    serial readout bit from the memory
//   LOAD_MODE         memory strobes; at most one is high at a time
//   RUN_MODE
//   OUTPUT_MODE
//   MEM_SERIAL_IN     HOST_SERIAL_IN passed through to the memory
//   OUT_BIT/OUT_VALID readout data to the host, one cycle behind OUTPUT_MODE
//   BUSY              high whenever the controller is not IDLE
//   DONE              one-cycle pulse after normal completion
//   GEN_DONE          generations completed in the current or last RUN
// -----------------------------------------------------------------------------
module system_memory_controller #(
    parameter int DATA_SIZE = 5,
    parameter int GEN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [GEN_WIDTH-1:0] CMD_GENS,
    input  logic                 ABORT,
    input  logic                 HOST_SERIAL_IN,
    input  logic                 HOST_SERIAL_VALID,
    input  logic                 MEM_SERIAL_OUT,
    output logic                 LOAD_MODE,
    output logic                 RUN_MODE,
    output logic                 OUTPUT_MODE,
    output logic                 MEM_SERIAL_IN,
    output logic                 OUT_BIT,
    output logic                 OUT_VALID,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [GEN_WIDTH-1:0] GEN_DONE
);

    localparam int            CW       = $clog2(DATA_SIZE + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_bit_cnt;
    logic [CW-1:0]        w_bit_cnt_next;
    logic [GEN_WIDTH-1:0] r_gens;
    logic [GEN_WIDTH-1:0] w_gens_next;
    logic [GEN_WIDTH-1:0] r_gen_done;
    logic [GEN_WIDTH-1:0] w_gen_done_next;
    logic                 r_done;
    logic                 w_done_next;
    logic                 r_out_valid;
    logic                 w_load_mode;
    logic [CW-1:0]        w_bit_inc;
    logic [GEN_WIDTH-1:0] w_gen_inc;

    // The strobes are decoded from the state, so the one-hot property holds
    // by construction. LOAD_MODE also needs valid host data.
    assign w_load_mode   = (r_state == ST_LOAD) && HOST_SERIAL_VALID;
    assign LOAD_MODE     = w_load_mode;
    assign RUN_MODE      = (r_state == ST_RUN);
    assign OUTPUT_MODE   = (r_state == ST_OUTPUT);
    assign CMD_READY     = (r_state == ST_IDLE);
    assign BUSY          = (r_state != ST_IDLE);
    assign MEM_SERIAL_IN = HOST_SERIAL_IN;
    assign OUT_VALID     = r_out_valid;
    assign OUT_BIT       = r_out_valid & MEM_SERIAL_OUT;
    assign DONE          = r_done;
    assign GEN_DONE      = r_gen_done;

    assign w_bit_inc = r_bit_cnt + 1'b1;
    assign w_gen_inc = r_gen_done + 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_gens      <= '0;
            r_gen_done  <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_gens      <= w_gens_next;
            r_gen_done  <= w_gen_done_next;
            r_done      <= w_done_next;
            // The memory registers its serial output on each OUTPUT_MODE
            // edge, so the readout data is valid one cycle after the strobe.
            r_out_valid <= (r_state == ST_OUTPUT);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_gens_next     = r_gens;
        w_gen_done_next = r_gen_done;
        w_done_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // ABORT has no meaning here. An accept always takes effect.
                if (CMD_VALID) begin
                    case (CMD_OP)
                        2'b01: begin
                            w_state_next   = ST_LOAD;
                            w_bit_cnt_next = '0;
                        end
                        2'b10: begin
                            w_gens_next     = CMD_GENS;
                            w_gen_done_next = '0;
                            // A zero-length RUN completes at the accept edge.
                            if (CMD_GENS == '0) begin
                                w_done_next = 1'b1;
                            end else begin
                                w_state_next = ST_RUN;
                            end
                        end
                        2'b11: begin
                            w_state_next   = ST_OUTPUT;
                            w_bit_cnt_next = '0;
                        end
                        default: ;
                    endcase
                end
            end

            ST_LOAD: begin
                if (ABORT) begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                end else if (w_load_mode) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next   = ST_IDLE;
                        w_bit_cnt_next = '0;
                        w_done_next    = 1'b1;
                    end else begin
                        w_bit_cnt_next = w_bit_inc;
                    end
                end
            end

            ST_RUN: begin
                // The memory advances one generation on every RUN_MODE edge,
                // including the edge that sees ABORT. The count therefore
                // always equals the number of generations actually computed.
                w_gen_done_next = w_gen_inc;
                if (ABORT) begin
                    w_state_next = ST_IDLE;
                end else if (w_gen_inc == r_gens) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end

            ST_OUTPUT: begin
                if (ABORT) begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                end else if (r_bit_cnt == LAST_BIT) begin
                    w_state_next   = ST_IDLE;
                    w_bit_cnt_next = '0;
                    w_done_next    = 1'b1;
                end else begin
                    w_bit_cnt_next = w_bit_inc;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_system_memory_controller.sv
// -----------------------------------------------------------------------------
// Testbench for system_memory_controller.
//
// A small behavioural stub of the system memory sits beside the DUT:
//   - LOAD_MODE shifts a bit in.
//   - RUN_MODE applies a simple next-state step.
//   - OUTPUT_MODE rotates the grid MSB first and registers the outgoing bit.
// The reference model tracks the expected grid contents and the GEN_DONE
// count one transaction at a time.
// -----------------------------------------------------------------------------
module tb_system_memory_controller;

    localparam int DS = 5;
    localparam int GW = 8;

    logic          CLK;
    logic          RESET;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [1:0]    CMD_OP;
    logic [GW-1:0] CMD_GENS;
    logic          ABORT;
    logic          HOST_SERIAL_IN;
    logic          HOST_SERIAL_VALID;
    logic          MEM_SERIAL_OUT;
    logic          LOAD_MODE;
    logic          RUN_MODE;
    logic          OUTPUT_MODE;
    logic          MEM_SERIAL_IN;
    logic          OUT_BIT;
    logic          OUT_VALID;
    logic          BUSY;
    logic          DONE;
    logic [GW-1:0] GEN_DONE;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DS-1:0] exp_grid;
    logic [GW-1:0] exp_gen_done;

    logic [DS-1:0] mem_q;
    logic          mem_sout;

    system_memory_controller #(
        .DATA_SIZE(DS),
        .GEN_WIDTH(GW)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .CMD_VALID         (CMD_VALID),
        .CMD_READY         (CMD_READY),
        .CMD_OP            (CMD_OP),
        .CMD_GENS          (CMD_GENS),
        .ABORT             (ABORT),
        .HOST_SERIAL_IN    (HOST_SERIAL_IN),
        .HOST_SERIAL_VALID (HOST_SERIAL_VALID),
        .MEM_SERIAL_OUT    (MEM_SERIAL_OUT),
        .LOAD_MODE         (LOAD_MODE),
        .RUN_MODE          (RUN_MODE),
        .OUTPUT_MODE       (OUTPUT_MODE),
        .MEM_SERIAL_IN     (MEM_SERIAL_IN),
        .OUT_BIT           (OUT_BIT),
        .OUT_VALID         (OUT_VALID),
        .BUSY              (BUSY),
        .DONE              (DONE),
        .GEN_DONE          (GEN_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory stub: the generation step shifts left and feeds back the
    // inverted MSB.
    always @(posedge CLK) begin
        if (LOAD_MODE) begin
            mem_q <= {mem_q[DS-2:0], MEM_SERIAL_IN};
        end else if (RUN_MODE) begin
            mem_q <= {mem_q[DS-2:0], ~mem_q[DS-1]};
        end else if (OUTPUT_MODE) begin
            mem_sout <= mem_q[DS-1];
            mem_q    <= {mem_q[DS-2:0], mem_q[DS-1]};
        end
    end
    assign MEM_SERIAL_OUT = mem_sout;

    function automatic logic [DS-1:0] rotl(input logic [DS-1:0] x);
        return {x[DS-2:0], x[DS-1]};
    endfunction

    function automatic logic [DS-1:0] gen_step(input logic [DS-1:0] x);
        return {x[DS-2:0], ~x[DS-1]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered at posedge+1 with the DUT idle. Returns at posedge+1 in the
    // first mode cycle. ABORT is raised at random on the accept edge, where
    // it must be ignored.
    task automatic accept(input logic [1:0] op, input logic [GW-1:0] gens);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_GENS  = gens;
        ABORT     = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check_eq("accept_ready", CMD_READY, 1);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_GENS  = GW'($urandom);
        ABORT     = 1'b0;
    endtask

    // Checks the first two IDLE cycles after an operation ends.
    task automatic finish_txn(input logic exp_done, input logic exp_trail, input logic trail_bit);
        @(negedge CLK);
        check_eq("end_done", DONE, exp_done);
        check_eq("end_ready", CMD_READY, 1);
        check_eq("end_busy", BUSY, 0);
        check_eq("end_modes", {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
        check_eq("end_out_valid", OUT_VALID, exp_trail);
        check_eq("end_out_bit", OUT_BIT, exp_trail ? trail_bit : 1'b0);
        check_eq("end_gen_done", GEN_DONE, exp_gen_done);
        @(posedge CLK); #1;
        @(negedge CLK);
        check_eq("post_done", DONE, 0);
        check_eq("post_out_valid", OUT_VALID, 0);
        check_eq("post_busy", BUSY, 0);
        check_eq("post_gen_done", GEN_DONE, exp_gen_done);
        check_eq("grid", mem_q, exp_grid);
        @(posedge CLK); #1;
    endtask

    // vpat != 0 gives a fixed valid pattern, read LSB first. Otherwise the
    // pattern is random.
    task automatic do_load(input logic [DS-1:0] bits, input logic [15:0] vpat);
        int   taken;
        int   cyc;
        logic v;
        taken = 0;
        cyc   = 0;
        accept(2'b01, '0);
        while (taken < DS && cyc < 100) begin
            v = (vpat != 16'h0) ? vpat[cyc[3:0]] : ($urandom_range(0, 2) != 0);
            HOST_SERIAL_VALID = v;
            HOST_SERIAL_IN    = v ? bits[DS-1-taken] : 1'($urandom);
            @(negedge CLK);
            check_eq("load_mode", LOAD_MODE, v);
            check_eq("load_ser_in", MEM_SERIAL_IN, HOST_SERIAL_IN);
            check_eq("load_ready", CMD_READY, 0);
            check_eq("load_busy", BUSY, 1);
            check_eq("load_other_modes", {RUN_MODE, OUTPUT_MODE}, 0);
            check_eq("load_done", DONE, 0);
            if (v) taken++;
            @(posedge CLK); #1;
            cyc++;
        end
        if (taken < DS) check_eq("load_timeout", taken, DS);
        HOST_SERIAL_VALID = 1'b0;
        HOST_SERIAL_IN    = 1'b0;
        exp_grid = bits;
        $display("TXN load bits=%b cycles=%0d", bits, cyc);
        finish_txn(1'b1, 1'b0, 1'b0);
    endtask

    // abort_at is the RUN cycle (1-based) in which ABORT is high; 0 means none.
    task automatic do_run(input int gens, input int abort_at);
        int   n;
        logic ab;
        n  = gens;
        ab = 1'b0;
        if (abort_at != 0 && abort_at <= gens) begin
            n  = abort_at;
            ab = 1'b1;
        end
        accept(2'b10, GW'(gens));
        for (int k = 1; k <= n; k++) begin
            ABORT             = (k == abort_at);
            CMD_VALID         = 1'($urandom);   // must be ignored while busy
            CMD_OP            = 2'b01;
            HOST_SERIAL_VALID = 1'($urandom);
            @(negedge CLK);
            check_eq("run_mode", RUN_MODE, 1);
            check_eq("run_other_modes", {LOAD_MODE, OUTPUT_MODE}, 0);
            check_eq("run_gen_done", GEN_DONE, k - 1);
            check_eq("run_ready", CMD_READY, 0);
            check_eq("run_done", DONE, 0);
            @(posedge CLK); #1;
            exp_grid = gen_step(exp_grid);
        end
        ABORT             = 1'b0;
        CMD_VALID         = 1'b0;
        HOST_SERIAL_VALID = 1'b0;
        exp_gen_done      = GW'(n);
        $display("TXN run gens=%0d abort_at=%0d run_cycles=%0d", gens, abort_at, n);
        finish_txn(!ab, 1'b0, 1'b0);
    endtask

    task automatic do_output(input int abort_at);
        int            n;
        logic          ab;
        logic [DS-1:0] prev;
        n    = DS;
        ab   = 1'b0;
        prev = exp_grid;
        if (abort_at != 0 && abort_at <= DS) begin
            n  = abort_at;
            ab = 1'b1;
        end
        accept(2'b11, '0);
        for (int k = 1; k <= n; k++) begin
            ABORT = (k == abort_at);
            @(negedge CLK);
            check_eq("out_mode", OUTPUT_MODE, 1);
            check_eq("out_other_modes", {LOAD_MODE, RUN_MODE}, 0);
            check_eq("out_valid", OUT_VALID, (k > 1));
            check_eq("out_bit", OUT_BIT, (k > 1) ? prev[DS-k+1] : 1'b0);
            check_eq("out_ready", CMD_READY, 0);
            @(posedge CLK); #1;
            exp_grid = rotl(exp_grid);
        end
        ABORT = 1'b0;
        $display("TXN output grid=%b abort_at=%0d out_cycles=%0d", prev, abort_at, n);
        finish_txn(!ab, 1'b1, prev[DS-n]);
    endtask

    // Drops RESET part-way through the second OUTPUT cycle, between clock
    // edges.
    task automatic do_reset_mid_output();
        accept(2'b11, '0);
        @(negedge CLK);
        check_eq("rst_out_mode_c1", OUTPUT_MODE, 1);
        @(posedge CLK); #1;
        exp_grid = rotl(exp_grid);
        check_eq("rst_out_valid_before", OUT_VALID, 1);
        #1 RESET = 1'b0;
        #1;
        check_eq("rst_out_mode_async", OUTPUT_MODE, 0);
        check_eq("rst_out_valid_async", OUT_VALID, 0);
        check_eq("rst_out_bit_async", OUT_BIT, 0);
        check_eq("rst_ready_async", CMD_READY, 1);
        check_eq("rst_busy_async", BUSY, 0);
        check_eq("rst_gen_done_async", GEN_DONE, 0);
        #1 RESET = 1'b1;
        exp_gen_done = '0;
        $display("TXN async reset during output");
        finish_txn(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        RESET             = 1'b0;
        CMD_VALID         = 1'b0;
        CMD_OP            = 2'b00;
        CMD_GENS          = '0;
        ABORT             = 1'b0;
        HOST_SERIAL_IN    = 1'b0;
        HOST_SERIAL_VALID = 1'b0;
        exp_grid          = '0;
        exp_gen_done      = '0;

        @(posedge CLK); #1;
        @(negedge CLK);
        check_eq("rst_modes", {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
        check_eq("rst_ready", CMD_READY, 1);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_flags", {OUT_VALID, OUT_BIT, DONE}, 0);
        check_eq("rst_gen_done", GEN_DONE, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("idle_ready", CMD_READY, 1);
        check_eq("idle_busy", BUSY, 0);
        check_eq("idle_modes", {LOAD_MODE, RUN_MODE, OUTPUT_MODE}, 0);
        $display("TXN reset");
        @(posedge CLK); #1;

        // A NOP is ignored and the controller stays idle.
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b00;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        @(negedge CLK);
        check_eq("nop_busy", BUSY, 0);
        check_eq("nop_ready", CMD_READY, 1);
        check_eq("nop_done", DONE, 0);
        $display("TXN nop");
        @(posedge CLK); #1;

        do_load(5'b01101, 16'h0073);   // bits 0,1, two-cycle gap, then 1,0,1
        do_output(0);
        do_run(3, 0);
        do_run(0, 0);
        do_run(10, 4);
        do_output(0);
        do_reset_mid_output();
        do_output(3);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            case (op)
                0: do_load(DS'($urandom), 16'h0);
                1: do_run($urandom_range(0, 12),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
                default: do_output(($urandom_range(0, 3) == 0) ? $urandom_range(1, DS) : 0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
